// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//
// Conditions the four raw, active-low board push-buttons for the rest of the
// system. Each key gets a two-flop synchronizer, a debounce FSM with its own
// stability counter, and registered level/press/release outputs. Keys are
// fully independent of one another.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synchronized level must hold before acceptance
//                    (1 .. 2^24-1)
//   REPEAT_DELAY     cycles from an accepted press to the first auto-repeat
//   REPEAT_PERIOD    cycles between later auto-repeat pulses
//
// Build option
//   KEY_AUTOREPEAT_EN  when defined, a held key re-pulses key_press after
//                      REPEAT_DELAY cycles and then every REPEAT_PERIOD
//                      cycles. When undefined, no repeat hardware exists.
//
// Ports
//   clk_clk      in   system clock, rising edge
//   reset_reset  in   synchronous, active-high reset
//   key_n_in     in   [3:0] raw keys, active-low, asynchronous to clk_clk
//   key_export   out  [3:0] debounced level, active-low (1 = released)
//   key_press    out  [3:0] one-cycle pulse on accepted press (and repeat)
//   key_release  out  [3:0] one-cycle pulse on accepted release

module key_debounce_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value whose increment reaches DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 16777215) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        ST_UP,
        ST_WAIT_DOWN,
        ST_DOWN,
        ST_WAIT_UP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s1;
    logic          s2;

`ifdef KEY_AUTOREPEAT_EN
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    // rpt_cnt counts held-down cycles since entry to DOWN (or since the last
    // repeat); rpt_first selects the initial delay versus the steady period.
    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic          rpt_hit;

    assign rpt_hit = (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));
`else
    // Repeat timing is meaningless in this build; only sanity-check it.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1            <= 1'b1;
            s2            <= 1'b1;
            state         <= ST_UP;
            cnt           <= '0;
            level         <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt       <= '0;
            rpt_first     <= 1'b1;
`endif
        end else begin
            s1            <= key_n;
            s2            <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;

            case (state)
                ST_UP: begin
                    if (!s2) begin
                        state <= ST_WAIT_DOWN;
                        cnt   <= '0;
                    end
                end

                ST_WAIT_DOWN: begin
                    if (s2) begin
                        state <= ST_UP;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= ST_DOWN;
                        cnt         <= '0;
                        level       <= 1'b0;
                        press_pulse <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt     <= '0;
                        rpt_first   <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DOWN: begin
                    if (s2) begin
                        state <= ST_WAIT_UP;
                        cnt   <= '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rpt_hit) begin
                        press_pulse <= 1'b1;
                        rpt_cnt     <= '0;
                        rpt_first   <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + RW'(1);
                    end
`endif
                end

                ST_WAIT_UP: begin
                    if (!s2) begin
                        // Release glitch: back to DOWN. The repeat counter was
                        // frozen during the glitch and this cycle counts as held.
                        state <= ST_DOWN;
                        cnt   <= '0;
`ifdef KEY_AUTOREPEAT_EN
                        if (rpt_hit) begin
                            press_pulse <= 1'b1;
                            rpt_cnt     <= '0;
                            rpt_first   <= 1'b0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RW'(1);
                        end
`endif
                    end else if (cnt == DB_LAST) begin
                        state         <= ST_UP;
                        cnt           <= '0;
                        level         <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= ST_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

module key_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] key_n_in,
    output logic [3:0] key_export,
    output logic [3:0] key_press,
    output logic [3:0] key_release
);
    localparam int NUM_KEYS = 4;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_lane (
            .clk          (clk_clk),
            .reset        (reset_reset),
            .key_n        (key_n_in[i]),
            .level        (key_export[i]),
            .press_pulse  (key_press[i]),
            .release_pulse(key_release[i])
        );
    end
endmodule

// File: doc/key_input_conditioner.md
KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), is the number of cycles a synchronized level must be stable before it is accepted; legal range 1..2^24-1.
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the cycles from an accepted press to the first auto-repeat pulse (KEY_AUTOREPEAT_EN only).
REQ-003 Parameter REPEAT_PERIOD, default 5000000, is the cycles between later auto-repeat pulses (KEY_AUTOREPEAT_EN only).
REQ-004 clk_clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset_reset  input  1  reset, synchronous and active-high.
REQ-006 key_n_in  input  4  raw board push-buttons, active-low, asynchronous to clk_clk.
REQ-007 key_export  output  4  debounced key level, active-low (1 = released); drives the key_export input of vga_image_viewer_system.
REQ-008 key_press  output  4  one-cycle pulse per bit on an accepted press (and on auto-repeat).
REQ-009 key_release  output  4  one-cycle pulse per bit on an accepted release.

Function
REQ-010 Each key_n_in bit shall pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 Each key shall have an independent FSM with states UP, WAIT_DOWN, DOWN and WAIT_UP, plus its own stability counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 UP: s2=0 -> WAIT_DOWN with counter cleared; otherwise stay.
REQ-013 WAIT_DOWN: s2=1 -> UP (glitch rejected, no pulse); else increment; on the increment that reaches DEBOUNCE_CYCLES -> DOWN.
REQ-014 On the UP/WAIT_DOWN -> DOWN transition, key_export bit shall go 0 and key_press bit shall pulse high for exactly one cycle, both registered on the same edge.
REQ-015 DOWN: s2=1 -> WAIT_UP with counter cleared; WAIT_UP mirrors WAIT_DOWN with polarity inverted (s2=0 returns to DOWN with no pulse).
REQ-016 On the WAIT_UP -> UP transition, key_export bit shall go 1 and key_release shall pulse for one cycle.
REQ-017 Latency: for a raw edge stable from edge N, key_export shall change at edge N+2+DEBOUNCE_CYCLES exactly.
REQ-018 A pulse shorter than DEBOUNCE_CYCLES cycles at s2 shall produce no change on any output.
REQ-019 Keys are independent; simultaneous transitions on several keys shall produce simultaneous pulses on the corresponding bits.
REQ-020 Counters shall saturate and never wrap; the counter shall hold at 0 in UP and DOWN.
REQ-021 key_press and key_release shall never both be high on the same bit in the same cycle.

Reset
REQ-022 While reset_reset=1 at a clock edge: all FSMs -> UP, counters=0, s1=s2=1, key_export=4'hF, key_press=4'h0, key_release=4'h0.
REQ-023 Reset mid-debounce or while DOWN shall discard state with no release pulse; a key held through reset shall be re-accepted as a press DEBOUNCE_CYCLES+2 cycles after the first non-reset edge.

Configuration
REQ-024 Macro KEY_AUTOREPEAT_EN: when defined, each key in DOWN shall additionally pulse key_press REPEAT_DELAY cycles after entry, then every REPEAT_PERIOD cycles, until it leaves DOWN; the repeat counter is cleared on entry to DOWN and held through WAIT_UP glitches.
REQ-025 Without KEY_AUTOREPEAT_EN, key_press shall pulse exactly once per accepted press, and no repeat counter or REPEAT_* logic shall be synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-026 Reset held 3 cycles -> key_export=4'hF, key_press=key_release=0 throughout and one cycle after release.
REQ-027 key_n_in[0] 1->0 at edge 10, held -> key_export[0]=0 and key_press[0]=1 at edge 16 only; release at edge 40 -> key_export[0]=1, key_release[0]=1 at edge 46.
REQ-028 key_n_in[2] low for 3 cycles then high -> no output change on any bit.
REQ-029 key_n_in[1] and [3] pressed at the same edge -> key_press=4'b1010 in one cycle, key_export=4'b0101.
REQ-030 reset_reset asserted while key 0 in WAIT_DOWN with key held -> outputs reset, press accepted 6 cycles after reset deassertion.
REQ-031 KEY_AUTOREPEAT_EN defined, key 0 held 50 cycles past acceptance -> key_press[0] pulses at +0, +20, +28, +36, +44; undefined -> only at +0.
